// File: rtl/lcd_hd44780_ctrl.sv
// Purpose: turns each CPU write of the LCD register into one HD44780 bus cycle (setup, EN pulse, hold, exec wait).
// Latency: EN rises 1+T_SETUP cycles after i_lcd_wr; busy clears T_SETUP+T_EN+T_HOLD+T_EXEC(_LONG) cycles after the write cycle.
// Backpressure: none on the bus side; one command is buffered while busy, further writes are dropped and flag overrun.
module lcd_hd44780_ctrl #(
    parameter int T_SETUP     = 3,
    parameter int T_EN        = 25,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_reg,
    input  logic        i_lcd_wr,
    input  logic        i_clr_ovr,
    input  logic [7:0]  i_lcd_data,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_data_oe,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic [31:0] o_status
);

    // One down-counter serves every timed state; each state loads (duration-1) on entry.
    localparam int CW = $clog2(T_EXEC_LONG + 1);
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] L_LONG  = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start;
    logic          use_pend;

    // Command word layout everywhere below: {RS, RW, DATA[7:0]}.
    logic [9:0]    new_cmd;
    logic [9:0]    cmd_q;
    logic [9:0]    pend_q;
    logic          pend_vld_q;
    logic          ovr_q;
    logic [7:0]    rdata_q;
    logic [9:0]    sel_cmd;
    logic          is_long;
    logic          busy;
    logic          pend_store;
    logic          pend_pop;
    logic          ovr_set;
    logic          unused_reg_bits;

    assign new_cmd         = i_lcd_reg[9:0];
    assign unused_reg_bits = ^i_lcd_reg[30:10];
    assign busy            = (state_q != S_IDLE);
    assign sel_cmd         = use_pend ? pend_q : new_cmd;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign is_long = ~cmd_q[9] & ~cmd_q[8] &
                     ((cmd_q[7:0] == 8'h01) | (cmd_q[7:0] == 8'h02) | (cmd_q[7:0] == 8'h03));

    // A buffered command always goes ahead of a new write; a write landing in that same
    // IDLE cycle refills the buffer rather than overrunning it.
    assign pend_store = i_lcd_wr & ((busy & ~pend_vld_q) | use_pend);
    assign pend_pop   = use_pend & ~i_lcd_wr;
    assign ovr_set    = i_lcd_wr & busy & pend_vld_q;

    // State and counter register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: each timed state exits when the counter has reached zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start    = 1'b0;
        use_pend = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pend_vld_q || i_lcd_wr) begin
                    start    = 1'b1;
                    use_pend = pend_vld_q;
                    state_d  = S_SETUP;
                    cnt_d    = L_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_EN_HI;
                    cnt_d   = L_EN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EN_HI: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = L_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = is_long ? L_LONG : L_EXEC;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Panel-side outputs: loaded at transaction start, bus released on entry to EXEC.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cmd_q         <= '0;
            o_lcd_rs      <= 1'b0;
            o_lcd_rw      <= 1'b0;
            o_lcd_data    <= '0;
            o_lcd_data_oe <= 1'b0;
            o_lcd_en      <= 1'b0;
            o_lcd_on      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            o_lcd_on <= i_lcd_reg[31];
            o_lcd_en <= (state_d == S_EN_HI);
            if (start) begin
                cmd_q         <= sel_cmd;
                o_lcd_rs      <= sel_cmd[9];
                o_lcd_rw      <= sel_cmd[8];
                o_lcd_data    <= sel_cmd[7:0];
                o_lcd_data_oe <= ~sel_cmd[8];
            end
            if (state_q == S_HOLD && state_d == S_EXEC) begin
                o_lcd_data_oe <= 1'b0;
                o_lcd_rw      <= 1'b0;
            end
            // Panel data is sampled at the end of the EN-high window, when it is settled.
            if (state_q == S_EN_HI && cnt_q == '0 && cmd_q[8]) begin
                rdata_q <= i_lcd_data;
            end
        end
    end

    // One-deep command buffer and sticky overrun flag (a new overrun beats a clear).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (pend_store) begin
                pend_q     <= new_cmd;
                pend_vld_q <= 1'b1;
            end else if (pend_pop) begin
                pend_vld_q <= 1'b0;
            end
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (i_clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign o_status = {busy, pend_vld_q, ovr_q, 21'd0, rdata_q};

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench: three instances (default timing, short exec, all-minimum timing)
// driven one after another from a single initial block; expected values are hand-derived.
module tb_lcd_hd44780_ctrl;

    localparam int LIMIT = 100000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lcd_reg;
    logic [7:0]  lcd_din;
    logic        wr_a, wr_b, wr_c;
    logic        clr_b;

    logic [7:0]  dout_a, dout_b, dout_c;
    logic        oe_a, oe_b, oe_c;
    logic        rs_a, rs_b, rs_c;
    logic        rw_a, rw_b, rw_c;
    logic        en_a, en_b, en_c;
    logic        on_a, on_b, on_c;
    logic [31:0] st_a, st_b, st_c;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    lcd_hd44780_ctrl u_a (
        .i_clk(clk), .i_rst(rst), .i_lcd_reg(lcd_reg), .i_lcd_wr(wr_a), .i_clr_ovr(1'b0),
        .i_lcd_data(lcd_din), .o_lcd_data(dout_a), .o_lcd_data_oe(oe_a), .o_lcd_rs(rs_a),
        .o_lcd_rw(rw_a), .o_lcd_en(en_a), .o_lcd_on(on_a), .o_status(st_a)
    );

    lcd_hd44780_ctrl #(.T_EXEC(20), .T_EXEC_LONG(50)) u_b (
        .i_clk(clk), .i_rst(rst), .i_lcd_reg(lcd_reg), .i_lcd_wr(wr_b), .i_clr_ovr(clr_b),
        .i_lcd_data(lcd_din), .o_lcd_data(dout_b), .o_lcd_data_oe(oe_b), .o_lcd_rs(rs_b),
        .o_lcd_rw(rw_b), .o_lcd_en(en_b), .o_lcd_on(on_b), .o_status(st_b)
    );

    lcd_hd44780_ctrl #(.T_SETUP(1), .T_EN(1), .T_HOLD(1), .T_EXEC(1), .T_EXEC_LONG(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_lcd_reg(lcd_reg), .i_lcd_wr(wr_c), .i_clr_ovr(1'b0),
        .i_lcd_data(lcd_din), .o_lcd_data(dout_c), .o_lcd_data_oe(oe_c), .o_lcd_rs(rs_c),
        .o_lcd_rw(rw_c), .o_lcd_en(en_c), .o_lcd_on(on_c), .o_status(st_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write strobe to instance 0/1/2; returns 1 ns after the sampling edge.
    task automatic strobe(input int which, input logic [31:0] v);
        lcd_reg = v;
        if (which == 0) wr_a = 1'b1;
        else if (which == 1) wr_b = 1'b1;
        else wr_c = 1'b1;
        tick();
        wr_a = 1'b0;
        wr_b = 1'b0;
        wr_c = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        int nrise;
        logic prev;
        logic saw_en;
        int rise [3];

        rst = 1'b0; lcd_reg = '0; lcd_din = '0;
        wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0; clr_b = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_status", st_a, 32'h0);
        chk("rst_en", en_a, 1'b0);
        chk("rst_oe", oe_a, 1'b0);
        chk("rst_on", on_a, 1'b0);
        rst = 1'b1;
        tick();

        // Function set 0x38 with panel on
        strobe(0, 32'h8000_0038);
        chk("t1_on", on_a, 1'b1);
        chk("t1_rs", rs_a, 1'b0);
        chk("t1_rw", rw_a, 1'b0);
        chk("t1_data", dout_a, 8'h38);
        chk("t1_oe", oe_a, 1'b1);
        chk("t1_busy", st_a[31], 1'b1);
        tick(); tick();
        chk("t1_en_before", en_a, 1'b0);
        tick();
        chk("t1_en_rise", en_a, 1'b1);
        m = 0;
        while (en_a && m < 100) begin tick(); m++; end
        chk("t1_en_width", m, 25);
        chk("t1_oe_hold", oe_a, 1'b1);
        tick(); tick();
        chk("t1_oe_exec", oe_a, 1'b0);
        n = 31;
        while (st_a[31] && n < LIMIT) begin tick(); n++; end
        chk("t1_busy_len", n, 1 + 3 + 25 + 2 + 2000);

        // Clear display uses the long execution wait
        strobe(0, 32'h0000_0001);
        chk("t2_on_off", on_a, 1'b0);
        chk("t2_data", dout_a, 8'h01);
        n = 1;
        while (st_a[31] && n < LIMIT) begin tick(); n++; end
        chk("t2_busy_len", n, 1 + 3 + 25 + 2 + 82000);

        // Busy-flag read on the short-exec instance
        lcd_din = 8'h80;
        strobe(1, 32'h0000_0100);
        chk("t3_oe", oe_b, 1'b0);
        chk("t3_rw", rw_b, 1'b1);
        n = 1;
        while (st_b[31] && n < LIMIT) begin tick(); n++; end
        chk("t3_busy_len", n, 1 + 3 + 25 + 2 + 20);
        chk("t3_status", st_b, 32'h0000_0080);
        lcd_din = 8'h00;

        // Three back-to-back writes: execute, buffer, drop
        lcd_reg = 32'h241; wr_b = 1'b1;
        tick();
        lcd_reg = 32'h242;
        tick();
        lcd_reg = 32'h243;
        tick();
        wr_b = 1'b0;
        chk("t4_data_41", dout_b, 8'h41);
        chk("t4_status", st_b, 32'hE000_0080);
        n = 3;
        while (st_b[31] && n < LIMIT) begin tick(); n++; end
        chk("t4_first_len", n, 51);
        chk("t4_pend_at_idle", st_b[30], 1'b1);
        tick();
        chk("t4_busy_again", st_b[31], 1'b1);
        chk("t4_pend_taken", st_b[30], 1'b0);
        chk("t4_data_42", dout_b, 8'h42);
        chk("t4_ovr_sticky", st_b[29], 1'b1);
        tick(); tick();
        chk("t4_en_before", en_b, 1'b0);
        tick();
        chk("t4_en_42", en_b, 1'b1);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("t4_ovr_clr", st_b[29], 1'b0);
        n = 0;
        while (st_b[31] && n < LIMIT) begin tick(); n++; end
        chk("t4_done", st_b[31], 1'b0);

        // Reset asserted during EN high, with a command buffered
        strobe(1, 32'h238);
        lcd_reg = 32'h239; wr_b = 1'b1;
        tick();
        wr_b = 1'b0;
        tick(); tick();
        chk("t5_en_hi", en_b, 1'b1);
        chk("t5_pend", st_b[30], 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_en_async", en_b, 1'b0);
        chk("t5_status", st_b, 32'h0);
        tick(); tick();
        rst = 1'b1;
        saw_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_en = saw_en | en_b | st_b[31];
        end
        chk("t5_no_replay", saw_en, 1'b0);

        // Minimum timing: strobes at t=0,1 and one landing on the IDLE cycle with a buffered command
        nrise = 0;
        prev  = 1'b0;
        for (int i = 0; i < 3; i++) rise[i] = -1;
        lcd_reg = 32'h241; wr_c = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (en_c && !prev) begin
                if (nrise < 3) rise[nrise] = t;
                nrise++;
            end
            prev = en_c;
            if (t == 1) begin
                lcd_reg = 32'h242; wr_c = 1'b1;
            end else if (t == 5) begin
                lcd_reg = 32'h243; wr_c = 1'b1;
            end else begin
                wr_c = 1'b0;
            end
        end
        chk("t6_pulses", nrise, 3);
        chk("t6_rise0", rise[0], 2);
        chk("t6_rise1", rise[1], 7);
        chk("t6_rise2", rise[2], 12);
        chk("t6_ovr", st_c[29], 1'b0);
        chk("t6_last_data", dout_c, 8'h43);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
